// File: rtl/uart_pkg.sv
// Shared UART types and line levels for the transmit framer and the future receiver.
// No logic: enums, constants and a parity helper only.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_t;

    localparam logic UART_IDLE  = 1'b1;
    localparam logic UART_START = 1'b0;
    localparam logic UART_STOP  = 1'b1;

    // Callers zero-extend narrower words; zero bits do not change the XOR.
    function automatic logic calc_parity(input logic [8:0] d, input logic odd);
        return (^d) ^ odd;
    endfunction

endpackage

// File: rtl/uart_tx_framer_if.sv
// Byte handover between upstream logic and the UART transmit framer.
// Valid/ready: a byte moves on any cycle where both are high.
interface uart_tx_framer_if #(
    parameter int DATA_BITS = 8
) ();
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_valid;
    logic                 tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_tick_detect.sv
// Rising-edge detector on a baud pulse; tick is combinational, same cycle as the 0->1 sample.
// Register resets high so a pulse already high at reset release never produces a tick.
module uart_tick_detect (
    input  logic clk,
    input  logic rst,
    input  logic pulse,
    output logic tick
);
    logic pulse_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            pulse_q <= 1'b1;
        end else begin
            pulse_q <= pulse;
        end
    end

    assign tick = pulse & ~pulse_q;
endmodule

// File: rtl/uart_tx_framer.sv
// UART transmitter: start, DATA_BITS LSB first, optional parity, 1-2 stop bits, paced by pulse_tx edges.
// Latency: tx moves on the tick edge; backpressure: tx_ready only in IDLE or the last stop bit.
module uart_tx_framer
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pulse_tx,
    uart_tx_framer_if.slave   up,
    output logic              tx,
    output logic              busy
);
    localparam int              CW        = $clog2(DATA_BITS);
    localparam logic [CW-1:0]   LAST_DATA = CW'(DATA_BITS - 1);
    localparam logic [CW-1:0]   LAST_STOP = CW'(STOP_BITS - 1);

    logic                 tick;
    uart_state_t          state, state_nxt;
    logic [DATA_BITS-1:0] shift_q, shift_nxt;
    logic [CW-1:0]        cnt_q, cnt_nxt;
    logic                 parity_q, parity_nxt;
    logic                 pending_q, pending_nxt;
    logic                 tx_nxt, busy_nxt;
    logic                 last_stop, accept;

    uart_tick_detect u_tick (
        .clk   (clk),
        .rst   (rst),
        .pulse (pulse_tx),
        .tick  (tick)
    );

    // pending marks a byte already taken during the last stop bit, to be sent with no idle gap.
    assign last_stop   = (cnt_q == LAST_STOP);
    assign up.tx_ready = (state == IDLE) || ((state == STOP) && last_stop && !pending_q);
    assign accept      = up.tx_valid && up.tx_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            shift_q   <= '0;
            cnt_q     <= '0;
            parity_q  <= 1'b0;
            pending_q <= 1'b0;
            tx        <= UART_IDLE;
            busy      <= 1'b0;
        end else begin
            state     <= state_nxt;
            shift_q   <= shift_nxt;
            cnt_q     <= cnt_nxt;
            parity_q  <= parity_nxt;
            pending_q <= pending_nxt;
            tx        <= tx_nxt;
            busy      <= busy_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        shift_nxt   = shift_q;
        cnt_nxt     = cnt_q;
        parity_nxt  = parity_q;
        pending_nxt = pending_q;
        tx_nxt      = tx;
        busy_nxt    = busy;

        if (accept) begin
            shift_nxt  = up.tx_data;
            parity_nxt = calc_parity(9'(up.tx_data), PARITY_ODD != 0);
            busy_nxt   = 1'b1;
        end

        case (state)
            IDLE: begin
                // A tick coinciding with accept is deliberately dropped; SYNC waits for the next one.
                if (accept) begin
                    state_nxt = SYNC;
                end
            end
            SYNC: begin
                if (tick) begin
                    state_nxt = START;
                    tx_nxt    = UART_START;
                end
            end
            START: begin
                if (tick) begin
                    state_nxt = DATA;
                    tx_nxt    = shift_q[0];
                    cnt_nxt   = '0;
                end
            end
            DATA: begin
                if (tick) begin
                    if (cnt_q == LAST_DATA) begin
                        cnt_nxt = '0;
                        if (PARITY_EN != 0) begin
                            state_nxt = PARITY;
                            tx_nxt    = parity_q;
                        end else begin
                            state_nxt = STOP;
                            tx_nxt    = UART_STOP;
                        end
                    end else begin
                        shift_nxt = shift_q >> 1;
                        tx_nxt    = shift_q[1];
                        cnt_nxt   = cnt_q + CW'(1);
                    end
                end
            end
            PARITY: begin
                if (tick) begin
                    state_nxt = STOP;
                    tx_nxt    = UART_STOP;
                    cnt_nxt   = '0;
                end
            end
            STOP: begin
                if (tick) begin
                    if (!last_stop) begin
                        cnt_nxt = cnt_q + CW'(1);
                    end else if (pending_q) begin
                        state_nxt   = START;
                        tx_nxt      = UART_START;
                        pending_nxt = 1'b0;
                    end else if (accept) begin
                        state_nxt = SYNC;
                    end else begin
                        state_nxt = IDLE;
                        tx_nxt    = UART_IDLE;
                        busy_nxt  = 1'b0;
                    end
                end else if (accept) begin
                    pending_nxt = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                tx_nxt    = UART_IDLE;
                busy_nxt  = 1'b0;
            end
        endcase
    end
endmodule

// File: tb/tb_uart_tx_framer.sv
// Scoreboard bench: four framers (8N1, 8E1, 8O1, 8N2) share clk, rst and a 16-clock baud pulse.
// Expected line values per tick are queued at accept; a monitor checks tx every cycle.
module tb_uart_tx_framer;

    logic clk = 1'b0;
    always #50 clk = ~clk;

    logic rst = 1'b1;
    logic pulse_tx = 1'b0;
    logic pulse_force = 1'b0;
    int   pc = 0;

    logic [7:0] data  [4];
    logic       valid [4];
    logic       ready [4];
    logic       txw   [4];
    logic       busyw [4];

    int n_pass  = 0;
    int n_total = 0;

    logic tx_q [4][$];
    logic exp_line [4];
    int   n_snap [4];
    logic pq_m   = 1'b1;
    logic tick_m = 1'b0;
    logic r_m    = 1'b1;

    uart_tx_framer_if #(.DATA_BITS(8)) if0 ();
    uart_tx_framer_if #(.DATA_BITS(8)) if1 ();
    uart_tx_framer_if #(.DATA_BITS(8)) if2 ();
    uart_tx_framer_if #(.DATA_BITS(8)) if3 ();

    assign if0.tx_data = data[0];  assign if0.tx_valid = valid[0];  assign ready[0] = if0.tx_ready;
    assign if1.tx_data = data[1];  assign if1.tx_valid = valid[1];  assign ready[1] = if1.tx_ready;
    assign if2.tx_data = data[2];  assign if2.tx_valid = valid[2];  assign ready[2] = if2.tx_ready;
    assign if3.tx_data = data[3];  assign if3.tx_valid = valid[3];  assign ready[3] = if3.tx_ready;

    uart_tx_framer #(.DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_8n1 (
        .clk(clk), .rst(rst), .pulse_tx(pulse_tx), .up(if0), .tx(txw[0]), .busy(busyw[0]));
    uart_tx_framer #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u_8e1 (
        .clk(clk), .rst(rst), .pulse_tx(pulse_tx), .up(if1), .tx(txw[1]), .busy(busyw[1]));
    uart_tx_framer #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u_8o1 (
        .clk(clk), .rst(rst), .pulse_tx(pulse_tx), .up(if2), .tx(txw[2]), .busy(busyw[2]));
    uart_tx_framer #(.DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) u_8n2 (
        .clk(clk), .rst(rst), .pulse_tx(pulse_tx), .up(if3), .tx(txw[3]), .busy(busyw[3]));

    // Baud pulse: period 16 clocks, high for 4; pc==0 marks the rising sample.
    always @(negedge clk) begin
        pc       = (pc == 15) ? 0 : pc + 1;
        pulse_tx = pulse_force | (pc < 4);
    end

    task automatic chk(input string nm, input int idx, input logic act, input logic expv);
        n_total++;
        if (act !== expv) begin
            $display("FAIL %s dut%0d: got %b, expected %b at %0t", nm, idx, act, expv, $time);
        end else begin
            n_pass++;
        end
    endtask

    // Queue depth is snapshotted at the edge so a byte accepted on this same edge cannot be consumed by it.
    always @(posedge clk) begin
        r_m    = rst;
        tick_m = pulse_tx & ~pq_m;
        pq_m   = r_m ? 1'b1 : pulse_tx;
        for (int i = 0; i < 4; i++) n_snap[i] = tx_q[i].size();
        #2;
        for (int i = 0; i < 4; i++) begin
            if (r_m) begin
                exp_line[i] = 1'b1;
            end else if (tick_m) begin
                exp_line[i] = (n_snap[i] > 0) ? tx_q[i].pop_front() : 1'b1;
            end
            chk("tx", i, txw[i], exp_line[i]);
        end
    end

    task automatic send(input int idx, input logic [7:0] d, input logic [15:0] seq,
                        input int len, input bit hold, input bit align);
        bit done = 1'b0;
        @(negedge clk); #1;
        if (align) begin
            for (int k = 0; k < 40 && pc != 0; k++) begin
                @(negedge clk); #1;
            end
            chk("ready_on_tick", idx, ready[idx], 1'b1);
        end
        data[idx]  = d;
        valid[idx] = 1'b1;
        for (int k = 0; k < 400 && !done; k++) begin
            if (ready[idx]) begin
                @(posedge clk); #1;
                for (int j = 0; j < len; j++) tx_q[idx].push_back(seq[j]);
                done = 1'b1;
            end else begin
                @(negedge clk); #1;
            end
        end
        chk("accept", idx, done, 1'b1);
        if (!hold) begin
            @(negedge clk); #1;
            valid[idx] = 1'b0;
            data[idx]  = ~d;
        end
    endtask

    task automatic wait_done(input int idx);
        bit ok = 1'b0;
        for (int k = 0; k < 600 && !ok; k++) begin
            @(posedge clk); #3;
            if (tx_q[idx].size() == 0) ok = 1'b1;
        end
        chk("drain", idx, ok, 1'b1);
        chk("busy_in_stop", idx, busyw[idx], 1'b1);
        ok = 1'b0;
        for (int k = 0; k < 40 && !ok; k++) begin
            @(posedge clk); #3;
            if (tick_m) ok = 1'b1;
        end
        chk("end_tick", idx, ok, 1'b1);
        chk("busy_clear", idx, busyw[idx], 1'b0);
        chk("ready_idle", idx, ready[idx], 1'b1);
        chk("tx_idle", idx, txw[idx], 1'b1);
    endtask

    task automatic idle_check(input int cycles);
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk); #1;
            for (int i = 0; i < 4; i++) begin
                chk("idle_ready", i, ready[i], 1'b1);
                chk("idle_busy", i, busyw[i], 1'b0);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, %0d/%0d checks passed", n_pass, n_total);
        $fatal(1);
    end

    initial begin
        bit ok;
        for (int i = 0; i < 4; i++) begin
            valid[i]    = 1'b0;
            data[i]     = 8'h00;
            exp_line[i] = 1'b1;
        end
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #3;
        for (int i = 0; i < 4; i++) begin
            chk("ready_after_reset", i, ready[i], 1'b1);
            chk("busy_after_reset", i, busyw[i], 1'b0);
        end
        idle_check(40);

        // 8N1 0x55: 0,1,0,1,0,1,0,1,0,1
        send(0, 8'h55, 16'h02AA, 10, 1'b0, 1'b0);
        wait_done(0);
        // 8E1 0x07: parity 1; 8O1 0x07: parity 0
        send(1, 8'h07, 16'h060E, 11, 1'b0, 1'b0);
        wait_done(1);
        send(2, 8'h07, 16'h040E, 11, 1'b0, 1'b0);
        wait_done(2);
        // 8N2 back-to-back 0xA3 then 0x3C with valid held
        send(3, 8'hA3, 16'h0746, 11, 1'b1, 1'b0);
        send(3, 8'h3C, 16'h0678, 11, 1'b0, 1'b0);
        wait_done(3);
        // accept on the same edge as a tick in IDLE: 0x81
        send(0, 8'h81, 16'h0302, 10, 1'b0, 1'b1);
        wait_done(0);

        // Reset during the 4th data bit of 0xF0 with pulse_tx held high across release
        send(0, 8'hF0, 16'h03E0, 10, 1'b0, 1'b0);
        ok = 1'b0;
        for (int k = 0; k < 400 && !ok; k++) begin
            @(posedge clk); #3;
            if (tx_q[0].size() == 5) ok = 1'b1;
        end
        chk("reach_bit3", 0, ok, 1'b1);
        for (int k = 0; k < 40 && pc != 1; k++) begin
            @(negedge clk); #1;
        end
        pulse_force = 1'b1;
        rst         = 1'b1;
        tx_q[0].delete();
        @(negedge clk); #1;
        @(negedge clk); #1;
        rst = 1'b0;
        repeat (20) @(negedge clk);
        #1;
        chk("rst_busy", 0, busyw[0], 1'b0);
        chk("rst_ready", 0, ready[0], 1'b1);
        pulse_force = 1'b0;
        idle_check(40);
        // clean frame after reset: 0x5A
        send(0, 8'h5A, 16'h02B4, 10, 1'b0, 1'b0);
        wait_done(0);
        idle_check(5);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
